// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared datapath types and constants for pipeline stages
package proc_pkg;

  // Occupancy of the two-entry skid buffer
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  // Every datapath register clears to all-zero bits
  localparam bit RESET_BIT = 1'b0;

endpackage

// File: rtl/flopr_en.sv
// rtl/flopr_en.sv - N-bit register with enable and synchronous active-high reset
import proc_pkg::*;

module flopr_en #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  // Reset wins over enable; otherwise load d only when enabled
  always_ff @(posedge clk) begin
    if (reset)
      q <= {N{RESET_BIT}};
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/flopr_skid.sv
// rtl/flopr_skid.sv - two-entry skid buffer pipeline register with valid/ready handshake
import proc_pkg::*;

module flopr_skid #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] q
);

  skid_state_t state, state_next;

  logic         accept;
  logic         fire;
  logic         main_en;
  logic         main_sel_skid;
  logic         skid_en;
  logic [N-1:0] main_d;
  logic [N-1:0] main_q;
  logic [N-1:0] skid_q;

  // Outputs come from registered state only, so ready/valid never chain combinationally
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign q         = main_q;

  assign accept = in_valid & in_ready;
  assign fire   = out_valid & out_ready;

  // Main refills from the skid entry when draining out of TWO, else from upstream
  assign main_d = main_sel_skid ? skid_q : d;

  // State register; reset discards any held words
  always_ff @(posedge clk) begin
    if (reset)
      state <= EMPTY;
    else
      state <= state_next;
  end

  // Next-state and register load enables
  always_comb begin
    state_next    = state;
    main_en       = 1'b0;
    main_sel_skid = 1'b0;
    skid_en       = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          main_en    = 1'b1;
          state_next = ONE;
        end
      end
      ONE: begin
        if (accept && fire) begin
          main_en = 1'b1;
        end else if (accept) begin
          skid_en    = 1'b1;
          state_next = TWO;
        end else if (fire) begin
          // main keeps its stale word; out_valid hides it
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (fire) begin
          main_en       = 1'b1;
          main_sel_skid = 1'b1;
          state_next    = ONE;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  flopr_en #(.N(N)) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  flopr_en #(.N(N)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en),
    .d     (d),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_flopr_skid.sv
// tb/tb_flopr_skid.sv - table-driven and scoreboard checks for flopr_skid
module tb_flopr_skid;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] d;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         rst;
    logic         iv;
    logic [N-1:0] din;
    logic         ordy;
    logic         ov;
    logic         ir;
    logic [N-1:0] qv;
    string        name;
  } vec_t;

  vec_t vecs[$];

  flopr_skid #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic iv, input logic [N-1:0] din,
                              input logic ordy, input logic ov, input logic ir,
                              input logic [N-1:0] qv, input string name);
    vec_t v;
    v.rst = rst; v.iv = iv; v.din = din; v.ordy = ordy;
    v.ov = ov; v.ir = ir; v.qv = qv; v.name = name;
    return v;
  endfunction

  // Scoreboard state for the randomized ordering run
  logic [N-1:0] expq[$];
  logic [N-1:0] next_word;
  int           sent;
  int           recvd;
  logic         acc;
  logic         fir;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    d         = '0;
    out_ready = 1'b0;

    // Reset hold with upstream pushing a word that must be ignored
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 1, 64'hAAAA, 0, 0, 1, 0, "reset_hold"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, "post_reset_idle"));
    // out_ready while EMPTY has no effect
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, "empty_ordy"));
    // Streaming 1..9 at full rate
    for (int k = 1; k <= 9; k++)
      vecs.push_back(mk(0, 1, 64'(k), 1, 1, 1, 64'(k), "stream"));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 64'd9, "stream_drain_stale"));
    // Stall fill 5, 6, then 7 refused
    vecs.push_back(mk(0, 1, 64'd5, 0, 1, 1, 64'd5, "stall_5"));
    vecs.push_back(mk(0, 1, 64'd6, 0, 1, 0, 64'd5, "stall_6_two"));
    vecs.push_back(mk(0, 1, 64'd7, 0, 1, 0, 64'd5, "stall_7_refused"));
    vecs.push_back(mk(0, 1, 64'd7, 0, 1, 0, 64'd5, "stall_7_held"));
    // Drain: 5 fires, 6 moves up and 7 is accepted, then 7 fires
    vecs.push_back(mk(0, 1, 64'd7, 1, 1, 1, 64'd6, "drain_6"));
    vecs.push_back(mk(0, 1, 64'd7, 1, 1, 1, 64'd7, "drain_7"));
    vecs.push_back(mk(0, 0, 64'd7, 1, 0, 1, 64'd7, "drain_empty"));
    // Simultaneous accept and fire in ONE
    vecs.push_back(mk(0, 1, 64'd3, 0, 1, 1, 64'd3, "one_3"));
    vecs.push_back(mk(0, 1, 64'd4, 1, 1, 1, 64'd4, "acc_fire_4"));
    vecs.push_back(mk(0, 0, 64'd0, 0, 1, 1, 64'd4, "stay_one"));
    // Reset mid-operation with 8 and 9 held
    vecs.push_back(mk(0, 0, 64'd0, 1, 0, 1, 64'd4, "to_empty"));
    vecs.push_back(mk(0, 1, 64'd8, 0, 1, 1, 64'd8, "fill_8"));
    vecs.push_back(mk(0, 1, 64'd9, 0, 1, 0, 64'd8, "fill_9_two"));
    vecs.push_back(mk(1, 1, 64'hA, 1, 0, 1, 64'd0, "mid_reset"));
    vecs.push_back(mk(0, 0, 64'd0, 1, 0, 1, 64'd0, "after_reset_1"));
    vecs.push_back(mk(0, 0, 64'd0, 1, 0, 1, 64'd0, "after_reset_2"));
    vecs.push_back(mk(0, 1, 64'h11, 0, 1, 1, 64'h11, "fresh_word"));
    vecs.push_back(mk(0, 0, 64'h0, 1, 0, 1, 64'h11, "fresh_drain"));

    foreach (vecs[i]) begin
      reset     = vecs[i].rst;
      in_valid  = vecs[i].iv;
      d         = vecs[i].din;
      out_ready = vecs[i].ordy;
      @(posedge clk);
      #1;
      chk({vecs[i].name, ".out_valid"}, N'(out_valid), N'(vecs[i].ov));
      chk({vecs[i].name, ".in_ready"},  N'(in_ready),  N'(vecs[i].ir));
      chk({vecs[i].name, ".q"},         q,             vecs[i].qv);
    end

    // Randomized back-pressure: words must leave in order, none lost or duplicated
    expq.delete();
    next_word = 64'h1000;
    sent      = 0;
    recvd     = 0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 300; c++) begin
      chk("rand.out_valid", N'(out_valid), N'(expq.size() != 0));
      chk("rand.in_ready",  N'(in_ready),  N'(expq.size() < 2));
      if (out_valid && expq.size() != 0)
        chk("rand.q", q, expq[0]);
      // Hold d while a presented word is still waiting to be accepted
      if (!(in_valid && !in_ready)) begin
        in_valid = 1'($urandom_range(0, 1));
        d        = next_word;
      end
      out_ready = 1'($urandom_range(0, 1));
      acc = in_valid & in_ready;
      fir = out_valid & out_ready;
      if (fir && expq.size() != 0) begin
        void'(expq.pop_front());
        recvd++;
      end
      if (acc) begin
        expq.push_back(d);
        sent++;
        next_word = next_word + 64'd1;
      end
      @(posedge clk);
      #1;
    end

    // Bounded drain of whatever is left
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && expq.size() != 0; c++) begin
      if (out_valid) begin
        chk("drain.q", q, expq[0]);
        void'(expq.pop_front());
        recvd++;
      end
      @(posedge clk);
      #1;
    end
    chk("drain.count", N'(recvd), N'(sent));
    chk("drain.out_valid", N'(out_valid), N'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
